text_line_writer: RTL and testbench
===================================

Name: text_line_writer

Overview:
- Builds the packed 16-character text bus consumed by the on-screen text renderer, as an editable line written one command at a time.
- Supports these operations:
  - append a character;
  - backspace;
  - clear;
  - append an unsigned number, converted to decimal digits in hardware.
- Sits between game/control logic (scores, labels, keyboard input) and the renderer, replacing hand-packed text constants.

Parameters:
- MAX_LETTERS, 16, character slots on the bus.
- CHAR_BITS, 6, bits per character code.
- NUM_BITS, 16, width of the number operand.
- BCD_DIGITS, 5, decimal digits needed for NUM_BITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  0 PUT_CHAR, 1 BACKSPACE, 2 CLEAR, 3 PUT_NUM.
- cmd_char  input  6  character code for PUT_CHAR.
- cmd_num  input  16  unsigned value for PUT_NUM.
- text  output  96  slot i in bits [6i+5:6i], slot 0 = first character.
- length  output  5  number of occupied slots, 0..16.
- full  output  1  length == 16.
- busy  output  1  PUT_NUM in progress.
- overflow  output  1  one-cycle pulse per dropped character.

Behaviour:
- Character codes:
  - 0 = blank/empty;
  - 1-26 = A-Z;
  - 27-52 = a-z;
  - 53-62 = digits 0-9 (digit d is 53+d);
  - 63 is reserved and stored as 0.
- A blank written mid-line is a space: it occupies a slot and advances length.
- Reset (asynchronous, immediate):
  - text=0, length=0, full=0, busy=0, overflow=0;
  - cmd_ready=1, state IDLE;
  - any in-progress conversion is abandoned.
- Handshake:
  - A command is accepted on the rising edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE), registered-state derived. It is not combinational on cmd_valid.
- All outputs are registered. Effects are visible the cycle after the accepting edge.
- PUT_CHAR:
  - If length<16: slot[length] <= cmd_char, length+1.
  - Else the character is dropped, text/length unchanged, overflow=1 for one cycle.
- BACKSPACE:
  - If length>0: slot[length-1] <= 0, length-1.
  - At length 0: no-op, no overflow.
- CLEAR: text <= 0, length <= 0 in one cycle.
- PUT_NUM state machine, IDLE -> CONVERT -> EMIT -> IDLE:
  - Accept edge E0: latch cmd_num, start the converter, enter CONVERT.
  - E1..E16: one double-dabble iteration per edge (add 3 to any BCD digit >=5, then shift left).
  - E16: enter EMIT. Digit pointer = most-significant nonzero BCD digit, or the units digit if the value is 0.
  - EMIT writes one digit per edge, most significant first, with the same append rule as PUT_CHAR. A digit written at length 16 is dropped and pulses overflow.
  - Dropped digits still consume their EMIT cycle.
  - The edge emitting the units digit returns to IDLE.
  - Total cmd_ready-low (busy-high) time = 16 + d cycles, where d = decimal digit count (1..5).
- Commands presented while busy are not accepted. The initiator holds cmd_valid and its operands.
- Timing: text is intentionally written into the renderer with one-cycle register lag. Text must not change within a frame unless the user intends it; this block imposes no frame sync.

Decomposition:
- Shared package text_codes_pkg holds:
  - MAX_LETTERS, CHAR_BITS;
  - CODE_BLANK=0, CODE_UPPER_A=1, CODE_LOWER_A=27, CODE_DIGIT_0=53, CODE_RESERVED=63;
  - the cmd_op encodings.
  - The renderer and future text sources use the same package.
- One sub-module, bin_to_bcd: sequential double-dabble with inputs start and value[15:0], outputs done and bcd[19:0], fixed 16-cycle latency. It also exposes a leading-digit index so EMIT needs no extra search cycle.

Test Plan:
- Reset, then PUT_CHAR 8,5,12,12,15 -> text[29:0] slots = 8,5,12,12,15 ("HELLO"), length=5, full=0, cmd_ready never drops.
- From length 0, PUT_NUM 1234 -> cmd_ready low exactly 20 cycles, final slots 0..3 = 54,55,56,57, length=4. PUT_NUM 0 -> slot=53, busy 17 cycles.
- PUT_NUM 65535 -> slots = 59,58,58,56,58, busy 21 cycles. Each digit appears on a successive cycle after the 16 convert cycles.
- Fill 16 slots, PUT_CHAR 1 -> overflow pulse, text unchanged, full=1. Then BACKSPACE -> slot15=0, length=15, full=0. BACKSPACE at length 0 -> no change.
- Length 14, PUT_NUM 12345 -> slots 14,15 = 54,55, three one-cycle overflow pulses, busy 21 cycles, length=16.
- Assert reset during CONVERT (e.g. cycle 7 of a PUT_NUM) -> text=0, length=0, busy=0, cmd_ready=1 asynchronously. A following CLEAR then PUT_CHAR 53 yields slot0=53, length=1.

Source files
------------

// File: rtl/text_codes_pkg.sv
// Shared text-code definitions for the on-screen text path.
// Holds the character code map, bus geometry and command encodings used by
// the line writer, the renderer and any future text source.
package text_codes_pkg;

    localparam int MAX_LETTERS = 16;  // character slots on the text bus
    localparam int CHAR_BITS   = 6;   // bits per character code
    localparam int NUM_BITS    = 16;  // width of the PUT_NUM operand
    localparam int BCD_DIGITS  = 5;   // decimal digits needed for NUM_BITS

    localparam logic [CHAR_BITS-1:0] CODE_BLANK    = 6'd0;
    localparam logic [CHAR_BITS-1:0] CODE_UPPER_A  = 6'd1;
    localparam logic [CHAR_BITS-1:0] CODE_LOWER_A  = 6'd27;
    localparam logic [CHAR_BITS-1:0] CODE_DIGIT_0  = 6'd53;
    localparam logic [CHAR_BITS-1:0] CODE_RESERVED = 6'd63;

    typedef enum logic [1:0] {
        OP_PUT_CHAR  = 2'd0,
        OP_BACKSPACE = 2'd1,
        OP_CLEAR     = 2'd2,
        OP_PUT_NUM   = 2'd3
    } cmd_op_t;

    // The reserved code has no glyph; it is stored as a blank.
    function automatic logic [CHAR_BITS-1:0] slot_code(input logic [CHAR_BITS-1:0] c);
        return (c == CODE_RESERVED) ? CODE_BLANK : c;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary to BCD converter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : load value and begin a 16-iteration conversion
//   value      : unsigned binary operand (sampled on the start edge)
//   done       : high in the cycle whose closing edge performs the final iteration
//   bcd        : BCD result, digit i in bits [4i+3:4i]; final after the done edge
//   lead       : index of the most significant nonzero digit of the result
//                being produced on the done edge (0 when the value is 0)
module bin_to_bcd
    import text_codes_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_BITS-1:0]     value,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic [2:0]              lead
);

    logic [NUM_BITS-1:0]     bin_reg;
    logic [4*BCD_DIGITS-1:0] bcd_reg;
    logic [4:0]              cnt_reg;   // iterations remaining
    logic [4*BCD_DIGITS-1:0] adj;
    logic [4*BCD_DIGITS-1:0] bcd_next;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_next = {adj[4*BCD_DIGITS-2:0], bin_reg[NUM_BITS-1]};

    // Leading digit is taken from the value being shifted in on the final
    // edge, so the caller can latch it without a separate search cycle.
    always_comb begin
        lead = 3'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) lead = 3'(i);
        end
    end

    assign done = (cnt_reg == 5'd1);
    assign bcd  = bcd_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            cnt_reg <= '0;
        end else if (start) begin
            bin_reg <= value;
            bcd_reg <= '0;
            cnt_reg <= 5'(NUM_BITS);
        end else if (cnt_reg != 5'd0) begin
            bin_reg <= {bin_reg[NUM_BITS-2:0], 1'b0};
            bcd_reg <= bcd_next;
            cnt_reg <= cnt_reg - 5'd1;
        end
    end

endmodule

// File: rtl/text_line_writer.sv
// Editable 16-character text line for the on-screen text renderer.
// Commands (one per accepted handshake): append character, backspace, clear,
// and append an unsigned number converted to decimal digits in hardware.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; ready is low while a number is in progress
//   cmd_op              : 0 PUT_CHAR, 1 BACKSPACE, 2 CLEAR, 3 PUT_NUM
//   cmd_char, cmd_num   : operands for PUT_CHAR / PUT_NUM
//   text                : packed slots, slot i in bits [6i+5:6i]
//   length, full        : occupied slot count and length==16 flag
//   busy                : PUT_NUM in progress
//   overflow            : one-cycle pulse per dropped character or digit
module text_line_writer
    import text_codes_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [CHAR_BITS-1:0]             cmd_char,
    input  logic [NUM_BITS-1:0]              cmd_num,
    output logic [MAX_LETTERS*CHAR_BITS-1:0] text,
    output logic [4:0]                       length,
    output logic                             full,
    output logic                             busy,
    output logic                             overflow
);

    typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_EMIT} state_t;

    state_t                  state_reg;
    logic [CHAR_BITS-1:0]    slots_reg [MAX_LETTERS];
    logic [4:0]              len_reg;
    logic                    full_reg;
    logic                    busy_reg;
    logic                    ready_reg;
    logic                    overflow_reg;
    logic [2:0]              ptr_reg;     // BCD digit being emitted

    logic                    accept;
    logic                    conv_start;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic [2:0]              conv_lead;
    logic [3:0]              emit_digit;
    logic                    append_en;
    logic [CHAR_BITS-1:0]    append_code;
    logic [4:0]              len_m1;

    assign accept     = cmd_valid && ready_reg;
    assign conv_start = accept && (cmd_op == OP_PUT_NUM);
    assign emit_digit = conv_bcd[{ptr_reg, 2'b00} +: 4];
    assign len_m1     = len_reg - 5'd1;

    // PUT_CHAR and EMIT share one append path; they can never coincide
    // because commands are only accepted in IDLE.
    always_comb begin
        append_en   = (accept && cmd_op == OP_PUT_CHAR) || (state_reg == ST_EMIT);
        append_code = (state_reg == ST_EMIT) ? CODE_DIGIT_0 + {2'b00, emit_digit}
                                             : slot_code(cmd_char);
    end

    bin_to_bcd u_bin_to_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .value (cmd_num),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .lead  (conv_lead)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            for (int i = 0; i < MAX_LETTERS; i++) slots_reg[i] <= CODE_BLANK;
            len_reg      <= '0;
            full_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            ptr_reg      <= '0;
        end else begin
            overflow_reg <= 1'b0;

            if (append_en) begin
                if (len_reg < 5'(MAX_LETTERS)) begin
                    slots_reg[len_reg[3:0]] <= append_code;
                    len_reg  <= len_reg + 5'd1;
                    full_reg <= (len_reg == 5'(MAX_LETTERS - 1));
                end else begin
                    overflow_reg <= 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_BACKSPACE: begin
                                if (len_reg != 5'd0) begin
                                    slots_reg[len_m1[3:0]] <= CODE_BLANK;
                                    len_reg  <= len_m1;
                                    full_reg <= 1'b0;
                                end
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < MAX_LETTERS; i++) slots_reg[i] <= CODE_BLANK;
                                len_reg  <= '0;
                                full_reg <= 1'b0;
                            end
                            OP_PUT_NUM: begin
                                state_reg <= ST_CONVERT;
                                busy_reg  <= 1'b1;
                                ready_reg <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        state_reg <= ST_EMIT;
                        ptr_reg   <= conv_lead;
                    end
                end
                ST_EMIT: begin
                    if (ptr_reg == 3'd0) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg - 3'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_LETTERS; gi++) begin : g_pack
            assign text[gi*CHAR_BITS +: CHAR_BITS] = slots_reg[gi];
        end
    endgenerate

    assign length    = len_reg;
    assign full      = full_reg;
    assign busy      = busy_reg;
    assign cmd_ready = ready_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_text_line_writer.sv
module tb_text_line_writer;
    import text_codes_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_char = 6'd0;
    logic [15:0] cmd_num = 16'd0;
    logic [95:0] text;
    logic [4:0]  length;
    logic        full;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int len_trace [0:63];

    always #5 clk = ~clk;

    text_line_writer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_char  (cmd_char),
        .cmd_num   (cmd_num),
        .text      (text),
        .length    (length),
        .full      (full),
        .busy      (busy),
        .overflow  (overflow)
    );

    // Present one command at a negedge and hold it through one rising edge.
    task automatic send(input logic [1:0] op, input logic [5:0] ch, input logic [15:0] num);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_op = op; cmd_char = ch; cmd_num = num; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Issue PUT_NUM and measure ready-low cycles, overflow pulses and length per cycle.
    task automatic run_num(input logic [15:0] num, output int busy_cycles, output int ovf);
        busy_cycles = 0; ovf = 0;
        send(OP_PUT_NUM, 6'd0, num);
        @(negedge clk);
        while (!cmd_ready && busy_cycles < 60) begin
            busy_cycles++;
            len_trace[busy_cycles] = length;
            if (overflow) ovf++;
            @(negedge clk);
        end
        if (overflow) ovf++;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (text !== 96'd0 || length !== 5'd0 || full !== 1'b0 || busy !== 1'b0 ||
            overflow !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: text=%h len=%0d full=%0b busy=%0b ovf=%0b rdy=%0b required all zero, rdy=1",
                     text, length, full, busy, overflow, cmd_ready);
        end
        reset = 1'b0;
    endtask

    task automatic test_put_char;
        logic [5:0] word [5];
        logic       dropped;
        word = '{6'd8, 6'd5, 6'd12, 6'd12, 6'd15};
        dropped = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(OP_PUT_CHAR, word[i], 16'd0);
            @(negedge clk);
            if (!cmd_ready) dropped = 1'b1;
        end
        checks++;
        if (text[29:0] !== {6'd15, 6'd12, 6'd12, 6'd5, 6'd8}) begin
            errors++; $display("FAIL hello_text: got %h required %h", text[29:0], {6'd15, 6'd12, 6'd12, 6'd5, 6'd8});
        end
        checks++;
        if (length !== 5'd5 || full !== 1'b0) begin
            errors++; $display("FAIL hello_len: len=%0d full=%0b required 5 0", length, full);
        end
        checks++;
        if (dropped !== 1'b0) begin
            errors++; $display("FAIL hello_ready: ready dropped=%0b required 0", dropped);
        end
        // Reserved code is stored as blank but still occupies a slot.
        send(OP_CLEAR, 6'd0, 16'd0);
        send(OP_PUT_CHAR, 6'd63, 16'd0);
        @(negedge clk);
        checks++;
        if (text !== 96'd0 || length !== 5'd1) begin
            errors++; $display("FAIL reserved_code: text=%h len=%0d required 0 1", text, length);
        end
    endtask

    task automatic test_put_num;
        int bc, ov;
        send(OP_CLEAR, 6'd0, 16'd0);
        run_num(16'd1234, bc, ov);
        checks++;
        if (bc !== 20) begin errors++; $display("FAIL num1234_busy: got %0d required 20", bc); end
        checks++;
        if (text[23:0] !== {6'd57, 6'd56, 6'd55, 6'd54} || length !== 5'd4) begin
            errors++; $display("FAIL num1234_text: got %h len=%0d required %h len=4", text[23:0], length, {6'd57, 6'd56, 6'd55, 6'd54});
        end

        send(OP_CLEAR, 6'd0, 16'd0);
        run_num(16'd0, bc, ov);
        checks++;
        if (bc !== 17 || text[5:0] !== 6'd53 || length !== 5'd1) begin
            errors++; $display("FAIL num0: busy=%0d slot0=%0d len=%0d required 17 53 1", bc, text[5:0], length);
        end

        send(OP_CLEAR, 6'd0, 16'd0);
        run_num(16'd65535, bc, ov);
        checks++;
        if (bc !== 21) begin errors++; $display("FAIL num65535_busy: got %0d required 21", bc); end
        checks++;
        if (text[29:0] !== {6'd58, 6'd56, 6'd58, 6'd58, 6'd59} || length !== 5'd5) begin
            errors++; $display("FAIL num65535_text: got %h len=%0d required %h len=5", text[29:0], length, {6'd58, 6'd56, 6'd58, 6'd58, 6'd59});
        end
        // Nothing written during convert; one digit per cycle afterwards.
        if (bc == 21) begin
            for (int k = 1; k <= 21; k++) begin
                int exp_len;
                exp_len = (k <= 17) ? 0 : k - 17;
                checks++;
                if (len_trace[k] !== exp_len) begin
                    errors++; $display("FAIL emit_seq cycle %0d: len=%0d required %0d", k, len_trace[k], exp_len);
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [95:0] exp_text;
        exp_text = '0;
        send(OP_CLEAR, 6'd0, 16'd0);
        for (int i = 0; i < 16; i++) begin
            send(OP_PUT_CHAR, 6'(i + 1), 16'd0);
            exp_text[i*6 +: 6] = 6'(i + 1);
        end
        @(negedge clk);
        checks++;
        if (text !== exp_text || length !== 5'd16 || full !== 1'b1) begin
            errors++; $display("FAIL fill16: text=%h len=%0d full=%0b required %h 16 1", text, length, full, exp_text);
        end
        send(OP_PUT_CHAR, 6'd1, 16'd0);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || text !== exp_text || full !== 1'b1 || length !== 5'd16) begin
            errors++; $display("FAIL char_overflow: ovf=%0b text=%h full=%0b len=%0d required 1 %h 1 16", overflow, text, full, length, exp_text);
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse: ovf=%0b required 0", overflow); end

        send(OP_BACKSPACE, 6'd0, 16'd0);
        @(negedge clk);
        exp_text[95:90] = 6'd0;
        checks++;
        if (text !== exp_text || length !== 5'd15 || full !== 1'b0) begin
            errors++; $display("FAIL backspace: text=%h len=%0d full=%0b required %h 15 0", text, length, full, exp_text);
        end

        send(OP_CLEAR, 6'd0, 16'd0);
        send(OP_BACKSPACE, 6'd0, 16'd0);
        @(negedge clk);
        checks++;
        if (text !== 96'd0 || length !== 5'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL backspace_empty: text=%h len=%0d ovf=%0b required 0 0 0", text, length, overflow);
        end
    endtask

    task automatic test_num_overflow;
        int bc, ov;
        send(OP_CLEAR, 6'd0, 16'd0);
        for (int i = 0; i < 14; i++) send(OP_PUT_CHAR, 6'd1, 16'd0);
        run_num(16'd12345, bc, ov);
        checks++;
        if (bc !== 21 || ov !== 3) begin
            errors++; $display("FAIL num_ovf_counts: busy=%0d ovf=%0d required 21 3", bc, ov);
        end
        checks++;
        if (text[95:84] !== {6'd55, 6'd54} || length !== 5'd16 || full !== 1'b1) begin
            errors++; $display("FAIL num_ovf_text: slots14,15=%h len=%0d full=%0b required %h 16 1", text[95:84], length, full, {6'd55, 6'd54});
        end
    endtask

    task automatic test_reset_mid_convert;
        send(OP_PUT_NUM, 6'd0, 16'd500);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%0b required 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (text !== 96'd0 || length !== 5'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: text=%h len=%0d busy=%0b rdy=%0b required 0 0 0 1", text, length, busy, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        send(OP_CLEAR, 6'd0, 16'd0);
        send(OP_PUT_CHAR, 6'd53, 16'd0);
        @(negedge clk);
        checks++;
        if (text[5:0] !== 6'd53 || length !== 5'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_reset: slot0=%0d len=%0d busy=%0b required 53 1 0", text[5:0], length, busy);
        end
    endtask

    initial begin
        test_reset;
        test_put_char;
        test_put_num;
        test_overflow;
        test_num_overflow;
        test_reset_mid_convert;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
